imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the RV32 pipeline. It serves the fetch requests issued by the program-counter stage and returns each instruction word after a fixed latency, strictly in request order. Responses wait in a bounded queue until the fetch stage can take them. A redirect flush (taken branch or jump resolved in Execute) discards all in-flight fetches in one cycle. The memory is word-addressed and windowed at the reset vector.

## Interface
- DATA_WIDTH, 32, instruction/address width
- DEPTH_WORDS, 1024, memory words (power of two)
- BASE_ADDR, 32'hBFC00000, byte address of word 0
- LATENCY, 2, cycles from request acceptance to response availability (>= 1)
- RSP_DEPTH, 4, maximum outstanding requests (power of two, >= LATENCY)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req_valid  in  1  fetch request valid
- req_ready  out  1  request accepted when req_valid && req_ready at rising edge
- req_addr  in  DATA_WIDTH  byte address of the fetch (the PC)
- flush  in  1  discard all outstanding and queued fetches
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at rising edge
- rsp_instr  out  DATA_WIDTH  instruction word
- rsp_addr  out  DATA_WIDTH  address of the fetch this response answers
- rsp_err  out  1  misaligned or out-of-window fetch
- load_we  in  1  memory write strobe (program loading)
- load_idx  in  log2(DEPTH_WORDS)  word index to write
- load_data  in  DATA_WIDTH  word to write

## Operation
- **Address decode:**
  - idx = (req_addr - BASE_ADDR) >> 2, computed modulo 2^32.
  - Error if req_addr[1:0] != 0, or (req_addr - BASE_ADDR) >= 4*DEPTH_WORDS (unsigned).
  - An error response carries rsp_instr = 32'h00000013 (NOP) and rsp_err = 1.
  - A normal response carries mem[idx] and rsp_err = 0.
- **Read pipeline:**
  - Shift register of LATENCY stages, each holding {valid, addr, err, idx/data}.
  - The memory read is registered at the final stage.
  - On reaching the end, the entry is pushed into a response FIFO of RSP_DEPTH entries.
- **Credit counter:**
  - count = entries in the pipeline + entries in the FIFO, range 0..RSP_DEPTH.
  - req_ready = (count < RSP_DEPTH) && !flush, driven from registered count only. There is no combinational path from rsp_ready or req_valid to req_ready.
  - Per cycle: count += accept, count -= pop. A simultaneous accept and pop leaves count unchanged.
  - Because the FIFO can never overflow, the pipeline never stalls.
- **Response FIFO:**
  - rsp_valid = FIFO non-empty.
  - rsp_* are driven from the FIFO head and stay stable while rsp_valid && !rsp_ready.
  - Pointers wrap modulo RSP_DEPTH.
- **Flush:**
  - Synchronous, takes priority over everything else.
  - At the edge where flush = 1: all pipeline valid bits clear, the FIFO empties, and count becomes 0.
  - No request is accepted in the flush cycle.
  - rsp_valid is low from the next cycle.
  - A pop in the flush cycle is irrelevant, since the FIFO is cleared either way.
- **Load port:**
  - Writes mem[load_idx] at the rising edge.
  - A read of the same word in the same cycle returns the old data (read-before-write).
  - Load is independent of flush and reset. Memory contents are not reset.

## Timing
- **Reset (rst = 0):**
  - Asynchronously clears pipeline valids, FIFO pointers and count.
  - Output values during reset: rsp_valid = 0, rsp_instr = 0, rsp_addr = 0, rsp_err = 0.
  - req_ready = 1 from the first cycle after rst deasserts.
- **Latency:** a request accepted at edge N is visible (rsp_valid = 1) in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles later, provided the FIFO ahead of it drains.
- **Throughput:** 1 request/cycle sustained when rsp_ready is held high.
- **Full:** with rsp_ready = 0, exactly RSP_DEPTH requests are accepted, then req_ready = 0. req_ready returns to 1 in the cycle after the first pop.
- **Reset mid-operation:** all outstanding fetches are lost. No response is produced for them after reset release.

## Test plan
- **Back-to-back fetch:**
  - Stimulus: load mem[0..3] = 11,22,33,44. Request 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C on consecutive cycles, rsp_ready = 1.
  - Required response: instrs 11,22,33,44 on 4 consecutive cycles, first one LATENCY cycles after the first accept, rsp_err = 0.
- **Errors:**
  - Stimulus: request 0xBFC00002, then 0xBFC01000 (DEPTH 1024), then 0x00000000.
  - Required response: three responses, each with rsp_err = 1, rsp_instr = 0x00000013, and rsp_addr echoing the request.
- **Backpressure/full:**
  - Stimulus: rsp_ready = 0, req_valid held high.
  - Required response: exactly 4 accepts, then req_ready = 0, and rsp_addr held stable. Raise rsp_ready for 1 cycle; then exactly one new accept occurs and the responses stay in order.
- **Flush:**
  - Stimulus: accept 3 requests, assert flush for 1 cycle while the last is in the pipeline, then request 0xBFC00010.
  - Required response: no responses for the flushed 3, req_ready = 0 during flush, and the only response is mem[4] after LATENCY cycles.
- **Simultaneous accept + pop at full:**
  - Stimulus: count = 4 with rsp_ready = 1 and req_valid = 1.
  - Required response: the pop occurs; the accept occurs the following cycle (req_ready is registered-derived); count never exceeds 4.
- **Async reset mid-stream:**
  - Stimulus: drive rst = 0 between clock edges with 2 fetches outstanding.
  - Required response: rsp_valid drops immediately; after release no stale response appears and req_ready = 1.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency, in-order fetch responses with a credit-bounded
// response queue, single-cycle redirect flush and a program-load write port.
module imem_responder #(
    parameter int unsigned              DATA_WIDTH  = 32,
    parameter int unsigned              DEPTH_WORDS = 1024,
    parameter logic [DATA_WIDTH-1:0]    BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned              LATENCY     = 2,
    parameter int unsigned              RSP_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [DATA_WIDTH-1:0]           req_addr,
    input  logic                            flush,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_instr,
    output logic [DATA_WIDTH-1:0]           rsp_addr,
    output logic                            rsp_err,
    input  logic                            load_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0]  load_idx,
    input  logic [DATA_WIDTH-1:0]           load_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h00000013);
    localparam logic [DATA_WIDTH-1:0] WIN_BYTES = DATA_WIDTH'(4 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(RSP_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W:0]        PTR_ONE   = (PTR_W + 1)'(1);

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH_WORDS];

    logic [DATA_WIDTH-1:0]  w_off;
    logic                   w_req_err;
    logic [IDX_W-1:0]       w_req_idx;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;

    logic                   w_tail_valid;
    logic [DATA_WIDTH-1:0]  w_tail_addr;
    logic                   w_tail_err;
    logic [IDX_W-1:0]       w_tail_idx;
    logic [DATA_WIDTH-1:0]  w_tail_data;

    logic [DATA_WIDTH-1:0]  r_fq_instr [RSP_DEPTH];
    logic [DATA_WIDTH-1:0]  r_fq_addr  [RSP_DEPTH];
    logic                   r_fq_err   [RSP_DEPTH];
    logic [PTR_W:0]         r_wr_ptr;
    logic [PTR_W:0]         r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    assign w_off     = req_addr - BASE_ADDR;
    assign w_req_err = (req_addr[1:0] != 2'b00) || (w_off >= WIN_BYTES);
    assign w_req_idx = w_off[IDX_W+1:2];

    // Credit check uses only the registered count; flush merely masks acceptance.
    assign req_ready = (r_count < CNT_MAX) && !flush;
    assign w_accept  = req_valid && req_ready;

    // The final latency stage is the FIFO write itself, so only LATENCY-1 shift stages exist.
    generate
        if (LATENCY == 1) begin : g_direct
            assign w_tail_valid = w_accept;
            assign w_tail_addr  = req_addr;
            assign w_tail_err   = w_req_err;
            assign w_tail_idx   = w_req_idx;
        end else begin : g_pipe
            localparam int unsigned NSTG = LATENCY - 1;

            logic                   r_pv [NSTG];
            logic [DATA_WIDTH-1:0]  r_pa [NSTG];
            logic                   r_pe [NSTG];
            logic [IDX_W-1:0]       r_pi [NSTG];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int unsigned s = 0; s < NSTG; s++) begin
                        r_pv[s] <= 1'b0;
                        r_pa[s] <= '0;
                        r_pe[s] <= 1'b0;
                        r_pi[s] <= '0;
                    end
                end else begin
                    r_pv[0] <= w_accept;
                    r_pa[0] <= req_addr;
                    r_pe[0] <= w_req_err;
                    r_pi[0] <= w_req_idx;
                    for (int unsigned s = 1; s < NSTG; s++) begin
                        r_pv[s] <= r_pv[s-1] && !flush;
                        r_pa[s] <= r_pa[s-1];
                        r_pe[s] <= r_pe[s-1];
                        r_pi[s] <= r_pi[s-1];
                    end
                end
            end

            assign w_tail_valid = r_pv[NSTG-1];
            assign w_tail_addr  = r_pa[NSTG-1];
            assign w_tail_err   = r_pe[NSTG-1];
            assign w_tail_idx   = r_pi[NSTG-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (load_we) begin
            r_mem[load_idx] <= load_data;
        end
    end

    assign w_tail_data = w_tail_err ? NOP_INSTR : r_mem[w_tail_idx];
    assign w_push      = w_tail_valid && !flush;
    assign w_pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fq_instr[r_wr_ptr[PTR_W-1:0]] <= w_tail_data;
            r_fq_addr[r_wr_ptr[PTR_W-1:0]]  <= w_tail_addr;
            r_fq_err[r_wr_ptr[PTR_W-1:0]]   <= w_tail_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head fields are forced to zero when empty so reset and flush show clean outputs.
    assign rsp_valid = (r_wr_ptr != r_rd_ptr);
    assign rsp_instr = rsp_valid ? r_fq_instr[r_rd_ptr[PTR_W-1:0]] : '0;
    assign rsp_addr  = rsp_valid ? r_fq_addr[r_rd_ptr[PTR_W-1:0]]  : '0;
    assign rsp_err   = rsp_valid ? r_fq_err[r_rd_ptr[PTR_W-1:0]]   : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: latency, errors, backpressure, flush and async reset.
module tb_imem_responder;

    localparam logic [31:0] BASE = 32'hBFC00000;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        load_we;
    logic [9:0]  load_idx;
    logic [31:0] load_data;

    int unsigned n_checks;
    int unsigned n_pass;

    imem_responder #(
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'hBFC00000),
        .LATENCY     (2),
        .RSP_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .load_we   (load_we),
        .load_idx  (load_idx),
        .load_data (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input int unsigned i);
        case (i)
            0:       return 32'd11;
            1:       return 32'd22;
            2:       return 32'd33;
            3:       return 32'd44;
            default: return 32'h10000000 + i;
        endcase
    endfunction

    logic [31:0] eaddr [3];

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        load_we   = 1'b0;
        load_idx  = '0;
        load_data = '0;
        eaddr[0]  = 32'hBFC00002;
        eaddr[1]  = 32'hBFC01000;
        eaddr[2]  = 32'h00000000;

        #2;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_instr", rsp_instr, 32'd0);
        check("rst_addr",  rsp_addr,  32'd0);
        check("rst_err",   32'(rsp_err), 32'd0);

        // Program load runs under reset; memory is not reset-controlled.
        for (int i = 0; i < 16; i++) begin
            load_we   = 1'b1;
            load_idx  = 10'(i);
            load_data = mem_word(i);
            step();
        end
        load_we = 1'b0;
        rst     = 1'b1;
        step();
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Back-to-back fetch
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                req_valid = 1'b1;
                req_addr  = BASE + 32'(4 * i);
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (i == 0) begin
                check("b2b_latency", 32'(rsp_valid), 32'd0);
            end else if (i <= 4) begin
                check("b2b_valid", 32'(rsp_valid), 32'd1);
                check("b2b_instr", rsp_instr, mem_word(i - 1));
                check("b2b_addr",  rsp_addr,  BASE + 32'(4 * (i - 1)));
                check("b2b_err",   32'(rsp_err), 32'd0);
            end else begin
                check("b2b_idle", 32'(rsp_valid), 32'd0);
            end
        end

        // Misaligned / out-of-window fetches
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                req_valid = 1'b1;
                req_addr  = eaddr[i];
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 3) begin
                check("err_valid", 32'(rsp_valid), 32'd1);
                check("err_flag",  32'(rsp_err), 32'd1);
                check("err_instr", rsp_instr, NOP);
                check("err_addr",  rsp_addr,  eaddr[i - 1]);
            end else if (i == 4) begin
                check("err_idle", 32'(rsp_valid), 32'd0);
            end
        end

        // Backpressure until full
        rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("full_ready", 32'(req_ready), 32'(k < 4));
            req_valid = 1'b1;
            req_addr  = BASE + 32'(4 * (4 + ((k < 4) ? k : 4)));
            step();
            if (k >= 1) begin
                check("full_valid",   32'(rsp_valid), 32'd1);
                check("full_hold_ad", rsp_addr, BASE + 32'h10);
            end
        end

        // Pop and request together at full: pop now, accept one cycle later
        check("accpop_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("accpop_head",  rsp_addr, BASE + 32'h14);
        check("accpop_ready1", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("accpop_full", 32'(req_ready), 32'd0);
        step();
        check("accpop_full2", 32'(req_ready), 32'd0);
        check("accpop_hold",  rsp_addr, BASE + 32'h14);
        rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("drain_valid", 32'(rsp_valid), 32'd1);
            check("drain_addr",  rsp_addr,  BASE + 32'(4 * (5 + j)));
            check("drain_instr", rsp_instr, mem_word(5 + j));
            step();
        end
        check("drain_empty", 32'(rsp_valid), 32'd0);

        // Flush with three fetches outstanding
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            req_addr  = BASE + 32'(4 * k);
            step();
        end
        flush    = 1'b1;
        req_addr = BASE + 32'h10;
        #1;
        check("flush_ready", 32'(req_ready), 32'd0);
        step();
        flush = 1'b0;
        check("flush_clear", 32'(rsp_valid), 32'd0);
        #1;
        check("flush_ready1", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("flush_lat", 32'(rsp_valid), 32'd0);
        step();
        check("flush_valid", 32'(rsp_valid), 32'd1);
        check("flush_instr", rsp_instr, mem_word(4));
        check("flush_addr",  rsp_addr,  BASE + 32'h10);
        check("flush_err",   32'(rsp_err), 32'd0);
        step();
        check("flush_idle", 32'(rsp_valid), 32'd0);
        step();
        check("flush_idle2", 32'(rsp_valid), 32'd0);

        // Async reset with two fetches outstanding
        rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid = 1'b1;
            req_addr  = BASE + 32'(4 * k);
            step();
        end
        req_valid = 1'b0;
        check("arst_pre", 32'(rsp_valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(rsp_valid), 32'd0);
        check("arst_instr", rsp_instr, 32'd0);
        step();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("arst_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("arst_stale", 32'(rsp_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
